// File: rtl/conv_transposed_1d_overlap_add.sv
// Overlap-add and crop stage of a transposed 1-D convolution: accumulates per-tap products
// into a K-deep circular buffer and streams finished samples. Optional macro: CONVT_OA_SAT_EN.
module conv_transposed_1d_overlap_add #(
  parameter int DATA_W         = 32,
  parameter int KERNEL_SIZE    = 3,
  parameter int STRIDE         = 1,
  parameter int PADDING        = 0,
  parameter int OUTPUT_PADDING = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last
`ifdef CONVT_OA_SAT_EN
  ,
  output logic                     sat_flag
`endif
);

  // Both streams: a beat transfers on a rising edge where valid && ready; a source
  // holds its valid and payload unchanged until that edge, and ready may not depend on valid.

  localparam int AW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int IW = $clog2(2 * KERNEL_SIZE);

  localparam logic [AW-1:0] TAP_LAST   = AW'(KERNEL_SIZE - 1);
  localparam logic [AW:0]   K_A        = (AW + 1)'(KERNEL_SIZE);
  localparam logic [IW-1:0] K_P        = IW'(KERNEL_SIZE);
  localparam logic [IW-1:0] P_P        = IW'(PADDING);
  localparam logic [IW-1:0] EMIT_LAST  = IW'(STRIDE - 1);
  localparam logic [IW-1:0] FLUSH_LAST = IW'(KERNEL_SIZE + OUTPUT_PADDING - 1);
  localparam logic [IW-1:0] KEEP_END   = IW'(KERNEL_SIZE + OUTPUT_PADDING - PADDING);
  localparam logic [IW-1:0] KEEP_LAST  = IW'(KERNEL_SIZE + OUTPUT_PADDING - PADDING - 1);

  if (STRIDE < 1 || STRIDE > KERNEL_SIZE || PADDING < 0 || PADDING >= KERNEL_SIZE ||
      OUTPUT_PADDING < 0 || OUTPUT_PADDING >= STRIDE) begin : g_param_check
    $fatal(1, "conv_transposed_1d_overlap_add: illegal STRIDE/PADDING/OUTPUT_PADDING");
  end

  typedef enum logic [1:0] {ACCUM, EMIT, FLUSH} state_t;

  state_t                    state_q, state_d;
  logic signed [DATA_W-1:0]  acc_q [KERNEL_SIZE];
  logic signed [DATA_W-1:0]  acc_d [KERNEL_SIZE];
  logic [AW-1:0]             base_q, base_d, tap_q, tap_d, base_nx;
  logic [IW-1:0]             pos_q, pos_d, raw_q, raw_d;
  logic [AW:0]               wr_sum;
  logic [AW-1:0]             wr_idx;
  logic signed [DATA_W-1:0]  add_res;
  logic                      advance, drop_d;
  logic                      out_valid_d, out_last_d, in_ready_d;
  logic signed [DATA_W-1:0]  value_d, out_data_d;

  assign wr_sum  = {1'b0, base_q} + {1'b0, tap_q};
  assign wr_idx  = (wr_sum >= K_A) ? AW'(wr_sum - K_A) : wr_sum[AW-1:0];
  assign base_nx = (base_q == TAP_LAST) ? '0 : base_q + 1'b1;

`ifdef CONVT_OA_SAT_EN
  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  logic signed [DATA_W:0] sum_ext;
  logic                   add_clamp;
  logic                   sat_d;
  assign sum_ext   = {acc_q[wr_idx][DATA_W-1], acc_q[wr_idx]} + {in_data[DATA_W-1], in_data};
  assign add_clamp = sum_ext[DATA_W] ^ sum_ext[DATA_W-1];
  assign add_res   = !add_clamp ? sum_ext[DATA_W-1:0] : (sum_ext[DATA_W] ? SAT_MIN : SAT_MAX);
`else
  assign add_res   = acc_q[wr_idx] + in_data;
`endif

  // A position advances when it is dropped (out_valid low) or its sample is taken.
  assign advance = (state_q != ACCUM) && (!out_valid || out_ready);

  always_comb begin
    acc_d   = acc_q;
    state_d = state_q;
    base_d  = base_q;
    tap_d   = tap_q;
    pos_d   = pos_q;
    raw_d   = raw_q;
`ifdef CONVT_OA_SAT_EN
    sat_d   = sat_flag;
`endif
    case (state_q)
      ACCUM: begin
        if (in_valid && in_ready) begin
          acc_d[wr_idx] = add_res;
`ifdef CONVT_OA_SAT_EN
          sat_d = sat_flag | add_clamp;
`endif
          if (tap_q == TAP_LAST) begin
            tap_d   = '0;
            pos_d   = '0;
            state_d = in_last ? FLUSH : EMIT;
          end else begin
            tap_d = tap_q + 1'b1;
          end
        end
      end
      default: begin
        if (advance) begin
          acc_d[base_q] = '0;
          base_d = base_nx;
          pos_d  = pos_q + 1'b1;
          if (raw_q != P_P) raw_d = raw_q + 1'b1;
          if (state_q == EMIT && pos_q == EMIT_LAST) begin
            state_d = ACCUM;
            pos_d   = '0;
          end
          if (state_q == FLUSH && pos_q == FLUSH_LAST) begin
            state_d = ACCUM;
            pos_d   = '0;
            raw_d   = '0;
            base_d  = '0;
`ifdef CONVT_OA_SAT_EN
            sat_d   = 1'b0;
`endif
          end
        end
      end
    endcase

    // Outputs are registered from next state, so the first position shows one cycle after tap K-1.
    drop_d      = (raw_d != P_P) || (state_d == FLUSH && pos_d >= KEEP_END);
    value_d     = (state_d == FLUSH && pos_d >= K_P) ? '0 : acc_d[base_d];
    out_valid_d = (state_d != ACCUM) && !drop_d;
    out_data_d  = out_valid_d ? value_d : '0;
    out_last_d  = out_valid_d && (state_d == FLUSH) && (pos_d == KEEP_LAST);
    in_ready_d  = (state_d == ACCUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KERNEL_SIZE; i++) acc_q[i] <= '0;
      state_q   <= ACCUM;
      base_q    <= '0;
      tap_q     <= '0;
      pos_q     <= '0;
      raw_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
`ifdef CONVT_OA_SAT_EN
      sat_flag  <= 1'b0;
`endif
    end else begin
      acc_q     <= acc_d;
      state_q   <= state_d;
      base_q    <= base_d;
      tap_q     <= tap_d;
      pos_q     <= pos_d;
      raw_q     <= raw_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_last  <= out_last_d;
`ifdef CONVT_OA_SAT_EN
      sat_flag  <= sat_d;
`endif
    end
  end

endmodule

// File: tb/tb_conv_transposed_1d_overlap_add.sv
// Directed scoreboard bench for conv_transposed_1d_overlap_add over five parameter sets
// (K=3: S1, S2, S2/OP1, S2/P1, and an 8-bit S1 unit for wrap/saturation).
module tb_conv_transposed_1d_overlap_add;
  localparam int NU = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NU-1:0] in_valid = '0;
  logic [NU-1:0] in_last  = '0;
  logic [NU-1:0] out_ready = '0;
  logic [NU-1:0] in_ready, out_valid, out_last;
  logic [31:0]   in_data [4];
  logic [31:0]   out_data [4];
  logic [7:0]    in_data_e = '0;
  logic [7:0]    out_data_e;
`ifdef CONVT_OA_SAT_EN
  logic [NU-1:0] sat_flag;
`endif

  conv_transposed_1d_overlap_add #(.DATA_W(32), .KERNEL_SIZE(3), .STRIDE(1), .PADDING(0), .OUTPUT_PADDING(0)) u_a (
`ifdef CONVT_OA_SAT_EN
    .sat_flag(sat_flag[0]),
`endif
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .in_last(in_last[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_last(out_last[0]));
  conv_transposed_1d_overlap_add #(.DATA_W(32), .KERNEL_SIZE(3), .STRIDE(2), .PADDING(0), .OUTPUT_PADDING(0)) u_b (
`ifdef CONVT_OA_SAT_EN
    .sat_flag(sat_flag[1]),
`endif
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .in_last(in_last[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_last(out_last[1]));
  conv_transposed_1d_overlap_add #(.DATA_W(32), .KERNEL_SIZE(3), .STRIDE(2), .PADDING(0), .OUTPUT_PADDING(1)) u_c (
`ifdef CONVT_OA_SAT_EN
    .sat_flag(sat_flag[2]),
`endif
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .in_last(in_last[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .out_last(out_last[2]));
  conv_transposed_1d_overlap_add #(.DATA_W(32), .KERNEL_SIZE(3), .STRIDE(2), .PADDING(1), .OUTPUT_PADDING(0)) u_d (
`ifdef CONVT_OA_SAT_EN
    .sat_flag(sat_flag[3]),
`endif
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_data(in_data[3]),
    .in_last(in_last[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_data(out_data[3]),
    .out_last(out_last[3]));
  conv_transposed_1d_overlap_add #(.DATA_W(8), .KERNEL_SIZE(3), .STRIDE(1), .PADDING(0), .OUTPUT_PADDING(0)) u_e (
`ifdef CONVT_OA_SAT_EN
    .sat_flag(sat_flag[4]),
`endif
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[4]), .in_ready(in_ready[4]), .in_data(in_data_e),
    .in_last(in_last[4]), .out_valid(out_valid[4]), .out_ready(out_ready[4]), .out_data(out_data_e),
    .out_last(out_last[4]));

  // Scoreboard state: {last, data} expected for the unit currently under test.
  logic [32:0] exp_q[$];
  int          cur_u = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [NU-1:0] hold_v = '0;
  logic [31:0] hold_d [NU];

  function automatic logic [31:0] out_val(input int u);
    if (u == 4) return {{24{out_data_e[7]}}, out_data_e};
    return out_data[u];
  endfunction

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Ready pattern: 0 = always ready, 1 = one cycle on / two off, 2 = never ready.
  int rdy_mode = 0;
  int rdy_cnt  = 0;
  always @(posedge clk) begin
    #1;
    rdy_cnt++;
    case (rdy_mode)
      0:       out_ready = '1;
      1:       out_ready = (rdy_cnt % 3 == 0) ? '1 : '0;
      default: out_ready = '0;
    endcase
  end

  // Monitor: samples on the falling edge, compares each accepted sample against the queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = '0;
    end else begin
      for (int u = 0; u < NU; u++) begin
        if (out_valid[u]) check("in_ready_low_while_out_valid", in_ready[u], 0);
        if (hold_v[u]) begin
          check("held_valid", out_valid[u], 1);
          check("held_data", out_val(u), hold_d[u]);
        end
        if (out_valid[u] && out_ready[u]) begin
          if (u != cur_u || exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: unit %0d got %0h, want no output", u, out_val(u));
          end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            check("out_data", out_val(u), e[31:0]);
            check("out_last", out_last[u], e[32]);
          end
        end
        hold_v[u] = out_valid[u] && !out_ready[u];
        hold_d[u] = out_val(u);
      end
    end
  end

  task automatic push(input logic [31:0] d, input logic last);
    exp_q.push_back({last, d});
  endtask

  task automatic send_beat(input int u, input logic [31:0] d, input logic last);
    int n;
    n = 0;
    in_valid[u] = 1'b1;
    in_last[u]  = last;
    if (u == 4) in_data_e = d[7:0];
    else in_data[u] = d;
    @(negedge clk);
    while (!in_ready[u] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[u]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: unit %0d got in_ready=0, want 1 within 200 cycles", u);
    end
    @(posedge clk);
    #1;
    in_valid[u] = 1'b0;
    in_last[u]  = 1'b0;
  endtask

  task automatic send_sample(input int u, input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic last, input logic early_last);
    send_beat(u, d0, early_last);
    send_beat(u, d1, early_last);
    send_beat(u, d2, last);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_drain: got %0d samples still expected, want 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) in_data[i] = '0;

    // Reset state of every unit.
    repeat (2) @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      check("reset_in_ready", in_ready[u], 0);
      check("reset_out_valid", out_valid[u], 0);
      check("reset_out_last", out_last[u], 0);
      check("reset_out_data", out_val(u), 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // K3 S1: 1,3,3,2; in_last on tap 0 must be ignored.
    cur_u = 0;
    push(1, 0); push(3, 0); push(3, 0); push(2, 1);
    send_sample(0, 1, 1, 1, 1'b0, 1'b1);
    send_sample(0, 2, 2, 2, 1'b1, 1'b0);
    drain("s1");

    // K3 S2 with a latency probe on the first emitted position.
    cur_u = 1;
    push(1, 0); push(1, 0); push(3, 0); push(2, 0); push(2, 1);
    send_sample(1, 1, 1, 1, 1'b0, 1'b0);
    @(negedge clk);
    check("first_emit_latency_valid", out_valid[1], 1);
    check("first_emit_latency_data", out_val(1), 1);
    send_sample(1, 2, 2, 2, 1'b1, 1'b0);
    drain("s2");

    // Same stimulus under backpressure.
    rdy_mode = 1;
    push(1, 0); push(1, 0); push(3, 0); push(2, 0); push(2, 1);
    send_sample(1, 1, 1, 1, 1'b0, 1'b0);
    send_sample(1, 2, 2, 2, 1'b1, 1'b0);
    drain("s2_backpressure");
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // K3 S2 OP1: trailing zero sample.
    cur_u = 2;
    push(1, 0); push(1, 0); push(3, 0); push(2, 0); push(2, 0); push(0, 1);
    send_sample(2, 1, 1, 1, 1'b0, 1'b0);
    send_sample(2, 2, 2, 2, 1'b1, 1'b0);
    drain("s2_op1");

    // K3 S2 P1: first and last raw positions cropped.
    cur_u = 3;
    push(1, 0); push(3, 0); push(2, 1);
    send_sample(3, 1, 1, 1, 1'b0, 1'b0);
    send_sample(3, 2, 2, 2, 1'b1, 1'b0);
    drain("s2_p1");

    // 8-bit unit: 100 + 100 overflows at the second position.
    cur_u = 4;
    push(32'd100, 0);
`ifdef CONVT_OA_SAT_EN
    push(32'd127, 0);
`else
    push(32'hFFFF_FFC8, 0);
`endif
    push(0, 0); push(0, 1);
    send_sample(4, 100, 100, 0, 1'b0, 1'b0);
    send_sample(4, 100, 0, 0, 1'b1, 1'b0);
`ifdef CONVT_OA_SAT_EN
    @(negedge clk);
    check("sat_flag_set", sat_flag[4], 1);
`endif
    drain("w8");
`ifdef CONVT_OA_SAT_EN
    check("sat_flag_cleared_after_flush", sat_flag[4], 0);
`endif

    // Reset mid-sequence: partial sums from sample0 must vanish.
    cur_u = 0;
    rdy_mode = 2;
    send_sample(0, 1, 1, 1, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_reset_pending_valid", out_valid[0], 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", out_valid[0], 0);
    check("async_reset_in_ready", in_ready[0], 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    push(5, 0); push(5, 0); push(5, 1);
    send_sample(0, 5, 5, 5, 1'b1, 1'b0);
    drain("reset_mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200000, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
